// File: rtl/sipo_latch_loader_pkg.sv
// Shared definitions for sipo_latch_loader.
// The 3-bit state encodings are kept in one place so that the latch-bank
// benches decode the state with the same values as the RTL.
package sipo_latch_loader_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SHIFT  = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_SETUP  = 3'd3;
    localparam logic [2:0] ST_PULSE  = 3'd4;
    localparam logic [2:0] ST_HOLD   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        PARITY = ST_PARITY,
        SETUP  = ST_SETUP,
        PULSE  = ST_PULSE,
        HOLD   = ST_HOLD
    } state_t;

endpackage

// File: rtl/sipo_latch_loader_pulse_timer.sv
// Down-counter that sets the width of the latch-enable pulse.
// A load presets the count to EN_CYCLES; the count then falls by one every
// cycle and expire is high while the count is zero.
module pulse_timer #(
    parameter int EN_CYCLES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic load,
    output logic expire
);

    localparam int TW = $clog2(EN_CYCLES + 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: preset on load, otherwise run down to zero and stay there
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = TW'(EN_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    // Count register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/sipo_latch_loader.sv
// Serial-in/parallel-out loader for a bank of WIDTH transparent latches.
// Collects WIDTH bits MSB-first, then presents LatchD one cycle before
// LatchEn rises, holds LatchEn for EN_CYCLES cycles and then pulses Done.
// Optional feature macro: PARITY_CHECK_EN adds a trailing even-parity bit;
// a mismatch pulses ParErr and drops the frame without touching the latches.
module sipo_latch_loader
    import sipo_latch_loader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EN_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             SerIn,
    input  logic             SerValid,
    output logic             Busy,
    output logic             Done,
    output logic             ParErr,
    output logic [WIDTH-1:0] LatchD,
    output logic             LatchEn
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] sr_q,       sr_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [WIDTH-1:0] latch_d_q,  latch_d_d;
    logic             latch_en_q, latch_en_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
`ifdef PARITY_CHECK_EN
    logic             par_err_q,  par_err_d;
`endif

    logic timer_load;
    logic timer_expire;

    pulse_timer #(
        .EN_CYCLES (EN_CYCLES)
    ) u_pulse_timer (
        .Clk    (Clk),
        .Reset  (Reset),
        .load   (timer_load),
        .expire (timer_expire)
    );

    // Next state and next values of every registered output
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        latch_d_d  = latch_d_q;
        latch_en_d = 1'b0;
        done_d     = 1'b0;
        timer_load = 1'b0;
`ifdef PARITY_CHECK_EN
        par_err_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // Serial data is ignored until a frame is started
                if (Start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end

            SHIFT: begin
                // SerValid low is a stall: nothing moves
                if (SerValid) begin
                    sr_d  = {sr_q[WIDTH-2:0], SerIn};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        state_d = SETUP;
`endif
                    end
                end
            end

`ifdef PARITY_CHECK_EN
            PARITY: begin
                // Even parity: the parity bit equals the XOR of the data bits
                if (SerValid) begin
                    if (SerIn == ^sr_q) begin
                        state_d = SETUP;
                    end else begin
                        par_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
`endif

            SETUP: begin
                // Data goes out a full cycle ahead of the enable for setup margin
                latch_d_d  = sr_q;
                timer_load = 1'b1;
                state_d    = PULSE;
            end

            PULSE: begin
                // Enable rises one cycle after entry and stays for EN_CYCLES cycles
                if (timer_expire) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                end else begin
                    latch_en_d = 1'b1;
                end
            end

            HOLD: begin
                // Enable already low, data still stable: hold margin cycle
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // FSM state, datapath and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            latch_d_q  <= '0;
            latch_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            latch_d_q  <= latch_d_d;
            latch_en_q <= latch_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef PARITY_CHECK_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign LatchD  = latch_d_q;
    assign LatchEn = latch_en_q;
`ifdef PARITY_CHECK_EN
    assign ParErr  = par_err_q;
`else
    assign ParErr  = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_latch_loader.sv
// Self-checking bench for sipo_latch_loader (WIDTH=8, EN_CYCLES=2).
// Drives a behavioural d_latch bank from LatchD/LatchEn and compares every
// frame against the documented latency rules. Honours PARITY_CHECK_EN.
`timescale 1ns/1ps
module tb_sipo_latch_loader;

    localparam int WIDTH     = 8;
    localparam int EN_CYCLES = 2;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic             SerIn;
    logic             SerValid;
    logic             Busy;
    logic             Done;
    logic             ParErr;
    logic [WIDTH-1:0] LatchD;
    logic             LatchEn;

    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] exp_latch;   // value the latch inputs are expected to hold
    int               checks   = 0;
    int               failures = 0;

    sipo_latch_loader #(
        .WIDTH     (WIDTH),
        .EN_CYCLES (EN_CYCLES)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .SerIn    (SerIn),
        .SerValid (SerValid),
        .Busy     (Busy),
        .Done     (Done),
        .ParErr   (ParErr),
        .LatchD   (LatchD),
        .LatchEn  (LatchEn)
    );

    always #5 Clk = ~Clk;

    // Downstream latch bank: transparent while LatchEn is high
    always_latch begin
        if (LatchEn) bank_q <= LatchD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // LatchD must never move while the enable is high
    logic [WIDTH-1:0] mon_d_prev  = '0;
    logic             mon_en_prev = 1'b0;
    always @(negedge Clk) begin
        if (mon_en_prev && LatchEn) check("d_stable_en", 32'(LatchD), 32'(mon_d_prev));
        mon_d_prev  <= LatchD;
        mon_en_prev <= LatchEn;
    end

    // One serial bit, optionally preceded by a stall cycle; called at a negedge
    task automatic send_bit(input logic b, input int mode, input logic poke);
        if (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1)) begin
            SerValid = 1'b0;
            SerIn    = 1'($urandom);
            Start    = poke;
            @(negedge Clk);
            check("shift_hold_d", 32'(LatchD), 32'(exp_latch));
            check("shift_en_low", 32'(LatchEn), 32'(0));
        end
        SerValid = 1'b1;
        SerIn    = b;
        Start    = 1'b0;
        @(negedge Clk);
        SerValid = 1'b0;
    endtask

    // Assert Start for one cycle (with a junk SerValid that IDLE must ignore)
    task automatic start_frame();
        check("idle_busy", 32'(Busy), 32'(0));
        Start    = 1'b1;
        SerValid = 1'b1;
        SerIn    = 1'($urandom);
        @(negedge Clk);
        Start    = 1'b0;
        SerValid = 1'b0;
        check("busy_after_start", 32'(Busy), 32'(1));
    endtask

    // Called at the negedge right after the final bit is accepted (edge N).
    // Offset k counts edges after N: D valid at k>=1, En high k=2..1+EN_CYCLES,
    // Done at k=2+EN_CYCLES, Busy low from k=3+EN_CYCLES.
    task automatic expect_load(input logic [WIDTH-1:0] data, input logic poke);
        for (int k = 0; k <= EN_CYCLES + 3; k++) begin
            check($sformatf("latchd_k%0d", k), 32'(LatchD), 32'(k >= 1 ? data : exp_latch));
            check($sformatf("latchen_k%0d", k), 32'(LatchEn), 32'((k >= 2 && k <= 1 + EN_CYCLES) ? 1 : 0));
            check($sformatf("done_k%0d", k), 32'(Done), 32'((k == 2 + EN_CYCLES) ? 1 : 0));
            check($sformatf("busy_k%0d", k), 32'(Busy), 32'((k <= 2 + EN_CYCLES) ? 1 : 0));
            check($sformatf("parerr_k%0d", k), 32'(ParErr), 32'(0));
            if (k < EN_CYCLES + 3) begin
                Start = (poke && (k == 2 || k == EN_CYCLES + 2)) ? 1'b1 : 1'b0;
                @(negedge Clk);
            end
        end
        Start     = 1'b0;
        exp_latch = data;
        check("bank_q", 32'(bank_q), 32'(data));
    endtask

    task automatic run_frame(input logic [WIDTH-1:0] data, input int mode, input logic poke);
        $display("frame data=0x%02h stall_mode=%0d start_poke=%0d", data, mode, poke);
        start_frame();
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(data[i], mode, poke);
`ifdef PARITY_CHECK_EN
        send_bit(^data, mode, poke);
`endif
        expect_load(data, poke);
    endtask

    initial begin
        Reset     = 1'b1;
        Start     = 1'b0;
        SerIn     = 1'b0;
        SerValid  = 1'b0;
        exp_latch = '0;
        @(negedge Clk);
        @(negedge Clk);
        check("rst_latchd", 32'(LatchD), 32'(0));
        check("rst_latchen", 32'(LatchEn), 32'(0));
        check("rst_busy", 32'(Busy), 32'(0));
        check("rst_done", 32'(Done), 32'(0));
        check("rst_parerr", 32'(ParErr), 32'(0));
        Reset = 1'b0;
        @(negedge Clk);

        // Contiguous frame, then the same result with alternating stalls
        run_frame(8'hA5, 0, 1'b0);
        run_frame(8'h3C, 1, 1'b0);

        // Reset after 4 bits: immediate clear, partial frame lost
        $display("frame data=0xFF aborted after 4 bits by reset");
        start_frame();
        for (int i = WIDTH - 1; i >= WIDTH - 4; i--) send_bit(1'b1, 0, 1'b0);
        #2 Reset = 1'b1;
        #1;
        check("mid_rst_latchd", 32'(LatchD), 32'(0));
        check("mid_rst_latchen", 32'(LatchEn), 32'(0));
        check("mid_rst_busy", 32'(Busy), 32'(0));
        check("mid_rst_done", 32'(Done), 32'(0));
        exp_latch = '0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        run_frame(8'hFF, 0, 1'b0);

        // Start pulses during SHIFT, PULSE and the Done cycle are ignored
        run_frame(8'h5A, 1, 1'b1);

        // Back-to-back frames, Start the cycle after Done
        run_frame(8'h01, 0, 1'b0);
        run_frame(8'h80, 1, 1'b0);

`ifdef PARITY_CHECK_EN
        // Bad parity: ParErr pulse, latches untouched, no Done
        $display("frame data=0xA5 with wrong parity");
        start_frame();
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(((8'hA5 >> i) & 8'h01) != 0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        check("perr_pulse", 32'(ParErr), 32'(1));
        check("perr_busy", 32'(Busy), 32'(0));
        for (int k = 0; k < 4; k++) begin
            check("perr_latchd", 32'(LatchD), 32'(exp_latch));
            check("perr_latchen", 32'(LatchEn), 32'(0));
            check("perr_done", 32'(Done), 32'(0));
            @(negedge Clk);
            check("perr_clear", 32'(ParErr), 32'(0));
        end
        run_frame(8'hA5, 0, 1'b0);
`endif

        // Randomised frames with random stalls and stray Start pulses
        for (int n = 0; n < 8; n++) begin
            run_frame(8'($urandom), int'($urandom_range(2, 0)), 1'($urandom));
        end

        @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
